// File: rtl/param_spram.sv
// Parameterised single-port RAM with byte-lane writes, power-up clear sweep and optional output register.
// Define SPRAM_PARITY_EN to store one even-parity bit per byte lane and report mismatches on reads.
module param_spram #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11,
    parameter int BYTE_W     = 8,
    parameter int WRITE_MODE = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W/BYTE_W-1:0] we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     busy,
    output logic                     parity_err
);
    // state | meaning
    // CLEAR | sweep zeroes one word per cycle, requests dropped, busy=1
    // READY | normal accesses, one per cycle, busy=0

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef SPRAM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int LANE_W = BYTE_W + PW;
    localparam int MEM_W  = NB * LANE_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    (* ram_style = "block" *) logic [MEM_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              clearing;
    logic              rd_issue;
    logic [NB-1:0]     lane_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  wword;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  merged;
    logic [MEM_W-1:0]  rsel;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
    logic              s1_perr;

    assign clearing  = (state == ST_CLEAR);
    assign busy      = clearing;
    // NO_CHANGE suppresses the read port on any write
    assign rd_issue  = !rst && !clearing && en && ((we == '0) || (WRITE_MODE != 2));
    assign mem_addr  = clearing ? sweep_cnt : addr;
    assign mem_wdata = clearing ? '0 : wword;
    assign rd_word   = mem[addr];
    assign rsel      = (WRITE_MODE == 1) ? merged : rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
        end else if (clearing) begin
            if (&sweep_cnt) begin
                state <= ST_READY;
            end else begin
                sweep_cnt <= sweep_cnt + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        lane_we = '0;
        if (!rst) begin
            if (clearing) begin
                lane_we = '1;
            end else if (en) begin
                lane_we = we;
            end
        end
    end

    always_comb begin
        wword   = '0;
        merged  = '0;
        rd_data = '0;
        rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
`ifdef SPRAM_PARITY_EN
            wword[i*LANE_W +: LANE_W] = {^din[i*BYTE_W +: BYTE_W], din[i*BYTE_W +: BYTE_W]};
`else
            wword[i*LANE_W +: LANE_W] = din[i*BYTE_W +: BYTE_W];
`endif
            merged[i*LANE_W +: LANE_W] = we[i] ? wword[i*LANE_W +: LANE_W]
                                               : rd_word[i*LANE_W +: LANE_W];
        end
        for (int i = 0; i < NB; i++) begin
            rd_data[i*BYTE_W +: BYTE_W] = rsel[i*LANE_W +: BYTE_W];
`ifdef SPRAM_PARITY_EN
            rd_perr = rd_perr | ((^rsel[i*LANE_W +: BYTE_W]) != rsel[i*LANE_W + BYTE_W]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                mem[mem_addr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_perr  <= 1'b0;
        end else begin
            s1_valid <= rd_issue;
            s1_perr  <= rd_issue & rd_perr;
            if (rd_issue) begin
                s1_data <= rd_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;
            logic              s2_perr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                    s2_perr  <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_perr  <= s1_perr;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign dout       = s2_data;
            assign dout_valid = s2_valid;
            assign parity_err = s2_perr;
        end else begin : g_noreg
            assign dout       = s1_data;
            assign dout_valid = s1_valid;
            assign parity_err = s1_perr;
        end
    endgenerate

endmodule
